// File: rtl/seg7_scan_controller_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller_if
//   Bundle between the application logic and the 7-segment scan controller.
//
//   Application side (master) drives:
//     enable       1 = scanning, 0 = display dark
//     data_in[7:0] [7:4] tens digit (digit 1), [3:0] units digit (digit 0)
//     load         one-cycle strobe capturing data_in into the pending buffer
//     blink_en[1:0] per-digit blink enable, bit i controls digit i
//     lz_suppress  blank digit 1 when its committed value is 0
//   Controller side (slave) drives:
//     bcd[3:0]            digit code to the shared segment decoder
//     Anode_Activate[1:0] active-low anodes, bit 0 = digit 0, bit 1 = digit 1
//     ack                 one-cycle pulse when pending data is committed
//     frame_tick          one-cycle pulse at the end of each full frame
// ---------------------------------------------------------------------------
interface seg7_scan_controller_if;
   logic       enable;
   logic [7:0] data_in;
   logic       load;
   logic [1:0] blink_en;
   logic       lz_suppress;
   logic [3:0] bcd;
   logic [1:0] Anode_Activate;
   logic       ack;
   logic       frame_tick;

   modport master (
      output enable, data_in, load, blink_en, lz_suppress,
      input  bcd, Anode_Activate, ack, frame_tick
   );

   modport slave (
      input  enable, data_in, load, blink_en, lz_suppress,
      output bcd, Anode_Activate, ack, frame_tick
   );
endinterface

// File: rtl/seg7_scan_controller.sv
// ---------------------------------------------------------------------------
// seg7_scan_controller
//   Time-multiplexes two hex/BCD digits onto a shared 7-segment decoder.
//   Each frame is SHOW0, BLANK0, SHOW1, BLANK1; the blank slots keep every
//   anode off so the decoder input can change without ghosting. New data is
//   double-buffered (pending -> shown) and only committed at a frame boundary
//   or when scanning starts, so a frame never mixes old and new digits.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  seg7_scan_controller_if.slave (see interface file for signals)
//
//   Parameters:
//     SLOT_CYCLES   clk cycles a digit is lit per slot (>= 2)
//     BLANK_CYCLES  clk cycles all anodes are off after each slot (>= 1)
//     BLINK_FRAMES  frames per blink half-period (>= 1)
// ---------------------------------------------------------------------------
module seg7_scan_controller #(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                    clk,
   input  logic                    rst,
   seg7_scan_controller_if.slave   bus
);

   localparam int MAX_CYC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHOW0,
      BLANK0,
      SHOW1,
      BLANK1
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     slot_cnt;
   logic [7:0]           pending;
   logic                 pend_valid;
   logic [7:0]           shown;
   logic [BLINK_W-1:0]   blink_cnt;
   logic                 blink_phase;
   logic [3:0]           bcd_q;
   logic [1:0]           anode_q;
   logic                 ack_q;
   logic                 frame_tick_q;

   logic slot_done;
   logic blank_done;
   logic frame_end;
   logic do_commit;
   logic sup0;
   logic sup1;

   assign slot_done  = (slot_cnt == SLOT_LAST);
   assign blank_done = (slot_cnt == BLANK_LAST);
   assign frame_end  = (state == BLANK1) && blank_done;

   // Commit happens when scanning starts and at every frame boundary.
   assign do_commit  = bus.enable && pend_valid && ((state == IDLE) || frame_end);

   // A suppressed digit keeps its slot timing but its anode stays off.
   assign sup0 = bus.blink_en[0] & blink_phase;
   assign sup1 = (bus.blink_en[1] & blink_phase) |
                 (bus.lz_suppress & (shown[7:4] == 4'h0));

   // NOTE: every register here uses non-blocking assignment so all of them
   // sample the same pre-edge values; blocking would make the outputs depend
   // on statement order instead of the previous state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         slot_cnt     <= '0;
         pending      <= 8'h00;
         pend_valid   <= 1'b0;
         shown        <= 8'h00;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         bcd_q        <= 4'h0;
         anode_q      <= 2'b11;
         ack_q        <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         ack_q        <= 1'b0;
         frame_tick_q <= 1'b0;

         if (!bus.enable) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            anode_q     <= 2'b11;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else begin
            // Outputs follow the state register by one cycle.
            case (state)
               SHOW0: begin
                  bcd_q   <= shown[3:0];
                  anode_q <= {1'b1, sup0};
               end
               SHOW1: begin
                  bcd_q   <= shown[7:4];
                  anode_q <= {sup1, 1'b1};
               end
               default: anode_q <= 2'b11;
            endcase

            case (state)
               IDLE: begin
                  state       <= SHOW0;
                  slot_cnt    <= '0;
                  blink_cnt   <= '0;
                  blink_phase <= 1'b0;
               end
               SHOW0: begin
                  if (slot_done) begin
                     state    <= BLANK0;
                     slot_cnt <= '0;
                  end else begin
                     slot_cnt <= slot_cnt + 1'b1;
                  end
               end
               BLANK0: begin
                  if (blank_done) begin
                     state    <= SHOW1;
                     slot_cnt <= '0;
                  end else begin
                     slot_cnt <= slot_cnt + 1'b1;
                  end
               end
               SHOW1: begin
                  if (slot_done) begin
                     state    <= BLANK1;
                     slot_cnt <= '0;
                  end else begin
                     slot_cnt <= slot_cnt + 1'b1;
                  end
               end
               BLANK1: begin
                  if (blank_done) begin
                     state        <= SHOW0;
                     slot_cnt     <= '0;
                     frame_tick_q <= 1'b1;
                     if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                     end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                     end
                  end else begin
                     slot_cnt <= slot_cnt + 1'b1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  slot_cnt <= '0;
               end
            endcase

            if (do_commit) begin
               shown      <= pending;
               pend_valid <= 1'b0;
               ack_q      <= 1'b1;
            end
         end

         // Placed after the commit so a load on the commit cycle keeps
         // pend_valid set: the later non-blocking assignment wins.
         if (bus.load) begin
            pending    <= bus.data_in;
            pend_valid <= 1'b1;
         end
      end
   end

   assign bus.bcd            = bcd_q;
   assign bus.Anode_Activate = anode_q;
   assign bus.ack            = ack_q;
   assign bus.frame_tick     = frame_tick_q;

endmodule
